// File: rtl/saturn_bus_ram_responder.sv
// saturn_bus_ram_responder
//   Memory device on the Saturn nibble bus, facing saturn_core's bus
//   controller. It tracks its own copies of the PC and DP address pointers,
//   can be configured to a base address, and serves nibble reads and writes
//   against an internal RAM of 2**ADDR_BITS nibbles. The RAM occupies a
//   window that is aligned to its own size.
//
// Parameters
//   ADDR_BITS  RAM address width (RAM holds 2**ADDR_BITS nibbles)
//   ID_VALUE   20-bit ID returned LSN-first by the ID command while unconfigured
//
// Ports
//   i_clk           system clock, rising edge
//   i_reset_n       asynchronous active-low reset
//   i_bus_reset     synchronous bus reset from the core, active high
//   i_bus_strobe    bus nibble valid this cycle
//   i_bus_cmd_data  1 = command nibble, 0 = data nibble
//   i_bus_data      nibble from the core
//   o_bus_data      nibble to the core (0 when not driving)
//   o_bus_drive     responder is driving o_bus_data
//   o_configured    base address loaded; device answers reads/writes
module saturn_bus_ram_responder #(
  parameter int unsigned ADDR_BITS = 8,
  parameter logic [19:0] ID_VALUE  = 20'h00005
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_bus_reset,
  input  logic       i_bus_strobe,
  input  logic       i_bus_cmd_data,
  input  logic [3:0] i_bus_data,
  output logic [3:0] o_bus_data,
  output logic       o_bus_drive,
  output logic       o_configured
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ID_OUT,
    ST_RD,
    ST_WR,
    ST_LD,
    ST_IGNORE
  } state_t;

  // Which register a RD/WR/LD state works on
  typedef enum logic [1:0] {
    SEL_PC,
    SEL_DP,
    SEL_BASE
  } sel_t;

  state_t      state_q, state_d;
  sel_t        sel_q, sel_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [19:0] pc_q, pc_d;
  logic [19:0] dp_q, dp_d;
  logic [19:0] base_q, base_d;
  logic        configured_q, configured_d;
  logic [3:0]  bus_data_q, bus_data_d;
  logic        bus_drive_q, bus_drive_d;

  logic [3:0]  mem [2**ADDR_BITS];

  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_waddr;
  logic [3:0]           mem_wdata;

  logic [19:0] ptr_cur;
  logic        hit_cur;
  logic [19:0] ld_val;
  logic [19:0] ptr_nxt;
  logic        hit_nxt;

  // Next-state and register-file update
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    cnt_d        = cnt_q;
    pc_d         = pc_q;
    dp_d         = dp_q;
    base_d       = base_q;
    configured_d = configured_q;
    mem_we       = 1'b0;
    mem_wdata    = i_bus_data;

    ptr_cur   = (sel_q == SEL_DP) ? dp_q : pc_q;
    hit_cur   = configured_q && (ptr_cur[19:ADDR_BITS] == base_q[19:ADDR_BITS]);
    mem_waddr = ptr_cur[ADDR_BITS-1:0];

    case (sel_q)
      SEL_DP:   ld_val = dp_q;
      SEL_BASE: ld_val = base_q;
      default:  ld_val = pc_q;
    endcase
    for (int unsigned i = 0; i < 5; i++) begin
      if (cnt_q == 3'(i)) ld_val[4*i +: 4] = i_bus_data;
    end

    if (i_bus_reset || (i_bus_strobe && i_bus_cmd_data && i_bus_data == 4'hF)) begin
      state_d      = ST_IDLE;
      sel_d        = SEL_PC;
      cnt_d        = '0;
      pc_d         = '0;
      dp_d         = '0;
      base_d       = '0;
      configured_d = 1'b0;
    end else if (i_bus_strobe && i_bus_cmd_data) begin
      cnt_d = '0;
      case (i_bus_data)
        4'h0: state_d = ST_IDLE;
        4'h1: state_d = ST_ID_OUT;
        4'h2: begin state_d = ST_RD; sel_d = SEL_PC;   end
        4'h3: begin state_d = ST_RD; sel_d = SEL_DP;   end
        4'h4: begin state_d = ST_WR; sel_d = SEL_PC;   end
        4'h5: begin state_d = ST_WR; sel_d = SEL_DP;   end
        4'h6: begin state_d = ST_LD; sel_d = SEL_PC;   end
        4'h7: begin state_d = ST_LD; sel_d = SEL_DP;   end
        4'h8: begin state_d = ST_LD; sel_d = SEL_BASE; end
        4'h9: begin state_d = ST_IDLE; configured_d = 1'b0; end
        default: state_d = ST_IGNORE;
      endcase
    end else if (i_bus_strobe) begin
      case (state_q)
        ST_ID_OUT: begin
          if (cnt_q == 3'd4) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        ST_RD, ST_WR: begin
          if (state_q == ST_WR) mem_we = hit_cur;
          if (sel_q == SEL_DP) dp_d = dp_q + 20'd1;
          else                 pc_d = pc_q + 20'd1;
        end
        ST_LD: begin
          case (sel_q)
            SEL_DP:   dp_d   = ld_val;
            SEL_BASE: base_d = ld_val;
            default:  pc_d   = ld_val;
          endcase
          if (cnt_q == 3'd4) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            if (sel_q == SEL_BASE) configured_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are computed from the post-update state so that a read presents
  // mem[ptr] one cycle after the command or data strobe that selected it.
  always_comb begin
    ptr_nxt     = (sel_d == SEL_DP) ? dp_d : pc_d;
    hit_nxt     = configured_d && (ptr_nxt[19:ADDR_BITS] == base_d[19:ADDR_BITS]);
    bus_drive_d = 1'b0;
    bus_data_d  = '0;
    case (state_d)
      ST_RD: begin
        bus_drive_d = hit_nxt;
        if (hit_nxt) bus_data_d = mem[ptr_nxt[ADDR_BITS-1:0]];
      end
      ST_ID_OUT: begin
        if (!configured_d) begin
          bus_drive_d = 1'b1;
          bus_data_d  = ID_VALUE[{cnt_d, 2'b00} +: 4];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= ST_IDLE;
      sel_q        <= SEL_PC;
      cnt_q        <= '0;
      pc_q         <= '0;
      dp_q         <= '0;
      base_q       <= '0;
      configured_q <= 1'b0;
      bus_data_q   <= '0;
      bus_drive_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      cnt_q        <= cnt_d;
      pc_q         <= pc_d;
      dp_q         <= dp_d;
      base_q       <= base_d;
      configured_q <= configured_d;
      bus_data_q   <= bus_data_d;
      bus_drive_q  <= bus_drive_d;
    end
  end

  // RAM contents survive both resets
  always_ff @(posedge i_clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign o_bus_data   = bus_data_q;
  assign o_bus_drive  = bus_drive_q;
  assign o_configured = configured_q;

endmodule

// File: tb/tb_saturn_bus_ram_responder.sv
module tb_saturn_bus_ram_responder;

  logic       i_clk = 1'b0;
  logic       i_reset_n = 1'b0;
  logic       i_bus_reset = 1'b0;
  logic       i_bus_strobe = 1'b0;
  logic       i_bus_cmd_data = 1'b0;
  logic [3:0] i_bus_data = '0;
  logic [3:0] o_bus_data;
  logic       o_bus_drive;
  logic       o_configured;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  saturn_bus_ram_responder #(.ADDR_BITS(8), .ID_VALUE(20'h00005)) dut (
    .i_clk          (i_clk),
    .i_reset_n      (i_reset_n),
    .i_bus_reset    (i_bus_reset),
    .i_bus_strobe   (i_bus_strobe),
    .i_bus_cmd_data (i_bus_cmd_data),
    .i_bus_data     (i_bus_data),
    .o_bus_data     (o_bus_data),
    .o_bus_drive    (o_bus_drive),
    .o_configured   (o_configured)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One strobe, then one idle cycle; returns at a falling edge with the
  // post-strobe outputs visible.
  task automatic strobe(input logic is_cmd, input logic [3:0] nib, input logic brst);
    @(negedge i_clk);
    i_bus_strobe   = 1'b1;
    i_bus_cmd_data = is_cmd;
    i_bus_data     = nib;
    i_bus_reset    = brst;
    @(negedge i_clk);
    i_bus_strobe   = 1'b0;
    i_bus_cmd_data = 1'b0;
    i_bus_data     = '0;
    i_bus_reset    = 1'b0;
  endtask

  task automatic cmd(input logic [3:0] c);
    strobe(1'b1, c, 1'b0);
  endtask

  task automatic dat(input logic [3:0] d);
    strobe(1'b0, d, 1'b0);
  endtask

  task automatic load(input logic [3:0] c, input logic [19:0] v);
    cmd(c);
    for (int i = 0; i < 5; i++) dat(v[4*i +: 4]);
  endtask

  task automatic chk_out(input string tag, input logic drv, input logic [3:0] d);
    check({tag, "_drive"}, {19'd0, o_bus_drive}, {19'd0, drv});
    check({tag, "_data"}, {16'd0, o_bus_data}, {16'd0, d});
  endtask

  initial begin
    repeat (2) @(negedge i_clk);
    check("rst_cfg", {19'd0, o_configured}, 20'd0);
    chk_out("rst", 1'b0, 4'h0);
    i_reset_n = 1'b1;

    // Configure to 02000, write 1,2 at 00..01 and A,B,C at 05..07
    load(4'h8, 20'h02000);
    check("cfg_set", {19'd0, o_configured}, 20'd1);
    load(4'h7, 20'h02000);
    cmd(4'h5); dat(4'h1); dat(4'h2);
    load(4'h7, 20'h02005);
    cmd(4'h5); dat(4'hA); dat(4'hB); dat(4'hC);
    load(4'h7, 20'h02005);
    cmd(4'h3);
    chk_out("rd0", 1'b1, 4'hA);
    dat(4'h0);
    chk_out("rd1", 1'b1, 4'hB);
    dat(4'h0);
    chk_out("rd2", 1'b1, 4'hC);

    // Async reset in the middle of a read
    @(negedge i_clk);
    i_reset_n = 1'b0;
    @(negedge i_clk);
    check("arst_cfg", {19'd0, o_configured}, 20'd0);
    chk_out("arst", 1'b0, 4'h0);
    i_reset_n = 1'b1;

    // Miss: base 02000, pc 03000
    load(4'h8, 20'h02000);
    load(4'h6, 20'h03000);
    cmd(4'h2);
    chk_out("miss_rd", 1'b0, 4'h0);
    cmd(4'h4); dat(4'h9);               // pc -> 03001, no write
    load(4'h8, 20'h03000);
    cmd(4'h2);
    chk_out("miss_pcinc", 1'b1, 4'h2);  // reads mem[01]
    load(4'h6, 20'h03000);
    cmd(4'h2);
    chk_out("miss_ramkeep", 1'b1, 4'h1);

    // Wrap FFFFF -> 00000 -> 00001
    load(4'h6, 20'hFFFFF);
    cmd(4'h2);
    chk_out("wrap_miss", 1'b0, 4'h0);
    dat(4'h0); dat(4'h0);
    load(4'h8, 20'h00000);
    cmd(4'h2);
    chk_out("wrap_pc", 1'b1, 4'h2);

    // Partial load keeps the upper pointer bits
    load(4'h8, 20'h00100);
    load(4'h7, 20'h00143);
    cmd(4'h5); dat(4'h7);               // mem[43]=7, dp -> 00144
    cmd(4'h7); dat(4'h3); dat(4'h4);
    cmd(4'h2);
    chk_out("abort_pc", 1'b0, 4'h0);
    cmd(4'h3);
    chk_out("abort_dp", 1'b1, 4'h7);

    // Unconfigure, then ID sequence
    cmd(4'h9);
    check("uncfg", {19'd0, o_configured}, 20'd0);
    cmd(4'h3);
    chk_out("uncfg_rd", 1'b0, 4'h0);
    cmd(4'h1);
    chk_out("id0", 1'b1, 4'h5);
    for (int i = 1; i < 5; i++) begin
      dat(4'h0);
      chk_out($sformatf("id%0d", i), 1'b1, 4'h0);
    end
    dat(4'h0);
    chk_out("id_end", 1'b0, 4'h0);
    load(4'h8, 20'h00100);
    cmd(4'h1);
    chk_out("id_cfg", 1'b0, 4'h0);

    // RESET command clears configuration
    cmd(4'hF);
    check("cmdF_cfg", {19'd0, o_configured}, 20'd0);

    // Bus reset beats a same-cycle DP_WRITE data strobe
    load(4'h8, 20'h00100);
    load(4'h7, 20'h00150);
    cmd(4'h5); dat(4'h6);               // mem[50]=6
    load(4'h7, 20'h00150);
    cmd(4'h5);
    strobe(1'b0, 4'h9, 1'b1);
    check("brst_cfg", {19'd0, o_configured}, 20'd0);
    chk_out("brst", 1'b0, 4'h0);
    load(4'h8, 20'h00100);
    load(4'h7, 20'h00150);
    cmd(4'h3);
    chk_out("brst_ram", 1'b1, 4'h6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
